// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Holds the operation codes and small decode helpers used by the datapath.
package mdu_iter_pkg;

  localparam logic [3:0] MDU_MULT  = 4'd0;
  localparam logic [3:0] MDU_MULTU = 4'd1;
  localparam logic [3:0] MDU_DIV   = 4'd2;
  localparam logic [3:0] MDU_DIVU  = 4'd3;
  localparam logic [3:0] MDU_MADD  = 4'd4;
  localparam logic [3:0] MDU_MADDU = 4'd5;
  localparam logic [3:0] MDU_MSUB  = 4'd6;
  localparam logic [3:0] MDU_MSUBU = 4'd7;
  localparam logic [3:0] MDU_MTHI  = 4'd8;
  localparam logic [3:0] MDU_MTLO  = 4'd9;
  localparam logic [3:0] MDU_MFHI  = 4'd10;
  localparam logic [3:0] MDU_MFLO  = 4'd11;

  function automatic logic mdu_is_arith(input logic [3:0] op);
    return (op <= MDU_MSUBU);
  endfunction

  function automatic logic mdu_is_div(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic mdu_is_signed(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV) || (op == MDU_MADD) || (op == MDU_MSUB);
  endfunction

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-division step: shift-in remainder vs divisor -> next remainder and quotient bit.
// Purely combinational; rem_i is always below 2*div_i so rem_o fits in WIDTH bits.
module mdu_divstep #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] diff;

  assign diff  = rem_i - {1'b0, div_i};
  assign q_o   = (rem_i >= {1'b0, div_i});
  assign rem_o = q_o ? diff[WIDTH-1:0] : rem_i[WIDTH-1:0];

endmodule

// File: rtl/mdu_iter.sv
// Iterative radix-2 HI/LO multiply/divide unit: WIDTH CALC cycles plus one FIX cycle.
// work_q is shared: {acc, multiplier} for multiplies, {remainder, dividend/quotient} for divides.
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             Start,
  input  logic             Flush,
  input  logic [3:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] DO,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           op_q, op_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [2*WIDTH-1:0]   work_q, work_d;
  logic                 q_neg_q, q_neg_d;
  logic                 r_neg_q, r_neg_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next, div_next;
  logic [WIDTH-1:0]     ds_rem;
  logic                 ds_q;
  logic [2*WIDTH-1:0]   prod, hilo;
  logic [WIDTH-1:0]     quo, rem;

  assign a_neg = mdu_is_signed(Op) & A[WIDTH-1];
  assign b_neg = mdu_is_signed(Op) & B[WIDTH-1];
  assign a_mag = a_neg ? ('0 - A) : A;
  assign b_mag = b_neg ? ('0 - B) : B;

  assign mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + {1'b0, (work_q[0] ? opb_q : '0)};
  assign mul_next = {mul_sum, work_q[WIDTH-1:1]};

  mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
    .rem_i (work_q[2*WIDTH-1:WIDTH-1]),
    .div_i (opb_q),
    .rem_o (ds_rem),
    .q_o   (ds_q)
  );
  assign div_next = {ds_rem, work_q[WIDTH-2:0], ds_q};

  assign prod = q_neg_q ? ('0 - work_q) : work_q;
  assign hilo = {hi_q, lo_q};
  assign quo  = q_neg_q ? ('0 - work_q[WIDTH-1:0]) : work_q[WIDTH-1:0];
  assign rem  = r_neg_q ? ('0 - work_q[2*WIDTH-1:WIDTH]) : work_q[2*WIDTH-1:WIDTH];

  assign Busy = (state_q != S_IDLE);
  assign DO   = (Op == MDU_MFHI) ? hi_q : (Op == MDU_MFLO) ? lo_q : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    opb_d   = opb_q;
    work_d  = work_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    Done    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (Start && !Flush) begin
          if (mdu_is_arith(Op)) begin
            state_d = S_CALC;
            cnt_d   = CNT_W'(WIDTH);
            op_d    = Op;
            if (mdu_is_div(Op)) begin
              work_d  = {{WIDTH{1'b0}}, a_mag};
              opb_d   = b_mag;
              // Divide-by-zero keeps a positive all-ones quotient; remainder then
              // naturally restores to A after the dividend sign is reapplied.
              q_neg_d = (a_neg ^ b_neg) & (|B);
              r_neg_d = a_neg;
            end else begin
              work_d  = {{WIDTH{1'b0}}, b_mag};
              opb_d   = a_mag;
              q_neg_d = a_neg ^ b_neg;
              r_neg_d = 1'b0;
            end
          end else if (Op == MDU_MTHI) begin
            hi_d = A;
          end else if (Op == MDU_MTLO) begin
            lo_d = A;
          end
        end
      end

      S_CALC: begin
        if (Flush) begin
          state_d = S_IDLE;
        end else begin
          work_d = mdu_is_div(op_q) ? div_next : mul_next;
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_FIX;
        end
      end

      S_FIX: begin
        state_d = S_IDLE;
        if (!Flush) begin
          Done = 1'b1;
          case (op_q)
            MDU_DIV, MDU_DIVU: begin
              lo_d = quo;
              hi_d = rem;
            end
            MDU_MADD, MDU_MADDU: {hi_d, lo_d} = hilo + prod;
            MDU_MSUB, MDU_MSUBU: {hi_d, lo_d} = hilo - prod;
            default:             {hi_d, lo_d} = prod;
          endcase
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      opb_q   <= '0;
      work_q  <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      opb_q   <= opb_d;
      work_q  <= work_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter at WIDTH=32 with hand-computed HI/LO results.
module tb_mdu_iter;
  import mdu_iter_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        Start;
  logic        Flush;
  logic [3:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] DO;
  logic        Busy;
  logic        Done;

  int n_cmp;
  int n_bad;

  mdu_iter #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .Start   (Start),
    .Flush   (Flush),
    .Op      (Op),
    .A       (A),
    .B       (B),
    .DO      (DO),
    .Busy    (Busy),
    .Done    (Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called 1ns after a rising edge; the request is accepted at the next edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    Op = op; A = a; B = b; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0; Op = MDU_MULT; A = '0; B = '0;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cyc, output int dones);
    busy_cyc = 0;
    dones    = 0;
    issue(op, a, b);
    while (Busy === 1'b1 && busy_cyc < 200) begin
      busy_cyc++;
      if (Done === 1'b1) dones++;
      @(posedge clk); #1;
    end
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    Op = MDU_MFHI; #1; hi = DO;
    Op = MDU_MFLO; #1; lo = DO;
    Op = MDU_MULT;
  endtask

  task automatic test_reset();
    logic [31:0] hi, lo;
    reset_n = 1'b0; Start = 1'b0; Flush = 1'b0; Op = MDU_MULT; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", Busy); end
    n_cmp++; if (Done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", Done); end
    read_hilo(hi, lo);
    n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL reset_hi got %h want 0", hi); end
    n_cmp++; if (lo !== 32'h0) begin n_bad++; $display("FAIL reset_lo got %h want 0", lo); end
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_mult();
    int bc, dn;
    logic [31:0] hi, lo;
    run_op(MDU_MULT, 32'hFFFFFFFE, 32'd3, bc, dn);
    n_cmp++; if (bc != 33) begin n_bad++; $display("FAIL mult_busy_cycles got %0d want 33", bc); end
    n_cmp++; if (dn != 1) begin n_bad++; $display("FAIL mult_done_pulses got %0d want 1", dn); end
    read_hilo(hi, lo);
    n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL mult_hi got %h want ffffffff", hi); end
    n_cmp++; if (lo !== 32'hFFFFFFFA) begin n_bad++; $display("FAIL mult_lo got %h want fffffffa", lo); end
    Op = MDU_MULT; #1;
    n_cmp++; if (DO !== 32'h0) begin n_bad++; $display("FAIL do_non_mf got %h want 0", DO); end
  endtask

  task automatic test_div();
    int bc, dn;
    logic [31:0] hi, lo;
    @(posedge clk); #1;
    run_op(MDU_DIV, 32'hFFFFFFF9, 32'd2, bc, dn);
    read_hilo(hi, lo);
    n_cmp++; if (lo !== 32'hFFFFFFFD) begin n_bad++; $display("FAIL div_lo got %h want fffffffd", lo); end
    n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL div_hi got %h want ffffffff", hi); end
    @(posedge clk); #1;
    run_op(MDU_DIVU, 32'd5, 32'd0, bc, dn);
    n_cmp++; if (bc != 33) begin n_bad++; $display("FAIL divz_busy_cycles got %0d want 33", bc); end
    n_cmp++; if (dn != 1) begin n_bad++; $display("FAIL divz_done_pulses got %0d want 1", dn); end
    read_hilo(hi, lo);
    n_cmp++; if (lo !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL divz_lo got %h want ffffffff", lo); end
    n_cmp++; if (hi !== 32'd5) begin n_bad++; $display("FAIL divz_hi got %h want 5", hi); end
  endtask

  task automatic test_macc();
    int bc, dn;
    logic [31:0] hi, lo;
    @(posedge clk); #1;
    issue(MDU_MTLO, 32'd10, 32'd0);
    n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL mt_busy got %b want 0", Busy); end
    issue(MDU_MTHI, 32'd0, 32'd0);
    read_hilo(hi, lo);
    n_cmp++; if (lo !== 32'd10) begin n_bad++; $display("FAIL mtlo got %h want a", lo); end
    n_cmp++; if (hi !== 32'd0) begin n_bad++; $display("FAIL mthi got %h want 0", hi); end
    @(posedge clk); #1;
    run_op(MDU_MADD, 32'd3, 32'd4, bc, dn);
    read_hilo(hi, lo);
    n_cmp++; if (lo !== 32'd22) begin n_bad++; $display("FAIL madd_lo got %h want 16", lo); end
    n_cmp++; if (hi !== 32'd0) begin n_bad++; $display("FAIL madd_hi got %h want 0", hi); end
    @(posedge clk); #1;
    run_op(MDU_MSUBU, 32'd1, 32'd23, bc, dn);
    read_hilo(hi, lo);
    n_cmp++; if (lo !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL msubu_lo got %h want ffffffff", lo); end
    n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL msubu_hi got %h want ffffffff", hi); end
  endtask

  task automatic test_overflow();
    int bc, dn;
    logic [31:0] hi, lo;
    @(posedge clk); #1;
    run_op(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, bc, dn);
    read_hilo(hi, lo);
    n_cmp++; if (lo !== 32'h80000000) begin n_bad++; $display("FAIL ovf_lo got %h want 80000000", lo); end
    n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL ovf_hi got %h want 0", hi); end
  endtask

  task automatic test_flush();
    int cyc, dn;
    logic [31:0] hi, lo;
    @(posedge clk); #1;
    issue(MDU_MULTU, 32'd7, 32'd9);
    cyc = 1;
    dn  = 0;
    while (cyc < 10) begin
      if (Done === 1'b1) dn++;
      if (cyc == 3) begin
        Start = 1'b1; Op = MDU_MTLO; A = 32'h1234;
      end else if (cyc == 5) begin
        Start = 1'b1; Op = MDU_DIVU; A = 32'd50; B = 32'd5;
      end else begin
        Start = 1'b0; Op = MDU_MULT;
      end
      @(posedge clk); #1;
      cyc++;
    end
    Start = 1'b0;
    n_cmp++; if (Busy !== 1'b1) begin n_bad++; $display("FAIL flush_busy_before got %b want 1", Busy); end
    if (Done === 1'b1) dn++;
    Flush = 1'b1;
    @(posedge clk); #1;
    Flush = 1'b0;
    n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL flush_busy_after got %b want 0", Busy); end
    repeat (3) begin
      if (Done === 1'b1) dn++;
      @(posedge clk); #1;
    end
    n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL flush_no_queue got busy %b want 0", Busy); end
    n_cmp++; if (dn != 0) begin n_bad++; $display("FAIL flush_done_pulses got %0d want 0", dn); end
    read_hilo(hi, lo);
    n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL flush_hi got %h want 0", hi); end
    n_cmp++; if (lo !== 32'h80000000) begin n_bad++; $display("FAIL flush_lo got %h want 80000000", lo); end
  endtask

  task automatic test_back_to_back();
    int bc, dn;
    logic [31:0] hi, lo;
    @(posedge clk); #1;
    run_op(MDU_MULTU, 32'd7, 32'd9, bc, dn);
    read_hilo(hi, lo);
    n_cmp++; if (lo !== 32'd63) begin n_bad++; $display("FAIL b2b_mul_lo got %h want 3f", lo); end
    n_cmp++; if (hi !== 32'd0) begin n_bad++; $display("FAIL b2b_mul_hi got %h want 0", hi); end
    run_op(MDU_DIVU, 32'd100, 32'd7, bc, dn);
    n_cmp++; if (bc != 33) begin n_bad++; $display("FAIL b2b_div_busy got %0d want 33", bc); end
    read_hilo(hi, lo);
    n_cmp++; if (lo !== 32'd14) begin n_bad++; $display("FAIL b2b_div_lo got %h want e", lo); end
    n_cmp++; if (hi !== 32'd2) begin n_bad++; $display("FAIL b2b_div_hi got %h want 2", hi); end
  endtask

  task automatic test_reset_mid();
    int dn, bz;
    logic [31:0] hi, lo;
    @(posedge clk); #1;
    issue(MDU_DIVU, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", Busy); end
    read_hilo(hi, lo);
    n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL rstmid_hi got %h want 0", hi); end
    n_cmp++; if (lo !== 32'h0) begin n_bad++; $display("FAIL rstmid_lo got %h want 0", lo); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    dn = 0;
    bz = 0;
    repeat (40) begin
      if (Done === 1'b1) dn++;
      if (Busy === 1'b1) bz++;
      @(posedge clk); #1;
    end
    n_cmp++; if (bz != 0) begin n_bad++; $display("FAIL rstmid_busy_after got %0d busy cycles want 0", bz); end
    n_cmp++; if (dn != 0) begin n_bad++; $display("FAIL rstmid_done got %0d pulses want 0", dn); end
    read_hilo(hi, lo);
    n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL rstmid_hi_after got %h want 0", hi); end
    n_cmp++; if (lo !== 32'h0) begin n_bad++; $display("FAIL rstmid_lo_after got %h want 0", lo); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_mult();
    test_div();
    test_macc();
    test_overflow();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
